// File: rtl/dfi_upd_lp_ctrl.sv
// dfi_upd_lp_ctrl: DFI ctrlupd/phyupd/phymstr/low-power arbiter; MC triggers and DFI acks in, DFI reqs/acks and busy/lp_active/lp_err status out
module dfi_upd_lp_ctrl #(
  parameter int TLP_RESP     = 8,
  parameter int TCTRLUPD_MIN = 4,
  parameter int TCTRLUPD_MAX = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init_start,
  input  logic       ctrlupd_trig,
  input  logic       lp_trig,
  input  logic [5:0] lp_wakeup_in,
  output logic       ctrlupd_req,
  input  logic       ctrlupd_ack,
  input  logic       phyupd_req,
  input  logic [1:0] phyupd_type,
  output logic       phyupd_ack,
  input  logic       phymstr_req,
  output logic       phymstr_ack,
  output logic       lp_ctrl_req,
  output logic [5:0] lp_ctrl_wakeup,
  input  logic       lp_ctrl_ack,
  output logic       lp_data_req,
  output logic [5:0] lp_data_wakeup,
  input  logic       lp_data_ack,
  output logic       busy,
  output logic       lp_active,
  output logic       lp_err
);
  typedef enum logic [2:0] {IDLE, CTRLUPD, PHYUPD, PHYMSTR, LP_REQ, LP_ACT, LP_EXIT} state_t;
  state_t state;
  logic [5:0] cnt, wake;
  logic ctrlupd_pend, ack_seen, ctrl_seen, data_seen, lp_req, unused_ok;
  int c1;
  assign c1 = int'(cnt) + 1;
  assign unused_ok = ^phyupd_type;
  assign lp_ctrl_req = lp_req;
  assign lp_data_req = lp_req;
  assign lp_ctrl_wakeup = wake;
  assign lp_data_wakeup = wake;
  assign busy = state != IDLE;
  assign lp_active = state == LP_ACT;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      wake <= '0;
      ctrlupd_pend <= 1'b0;
      ack_seen <= 1'b0;
      ctrl_seen <= 1'b0;
      data_seen <= 1'b0;
      lp_req <= 1'b0;
      ctrlupd_req <= 1'b0;
      phyupd_ack <= 1'b0;
      phymstr_ack <= 1'b0;
      lp_err <= 1'b0;
    end else begin
      cnt <= &cnt ? cnt : cnt + 6'd1;
      lp_err <= 1'b0;
      ctrlupd_pend <= ctrlupd_pend | ctrlupd_trig;
      case (state)
        IDLE: if (!init_start) begin
          if (phymstr_req) begin
            state <= PHYMSTR;
            cnt <= '0;
          end else if (phyupd_req) begin
            state <= PHYUPD;
            cnt <= '0;
          end else if (ctrlupd_pend) begin
            state <= CTRLUPD;
            cnt <= '0;
            ctrlupd_req <= 1'b1;
            ctrlupd_pend <= 1'b0;
            ack_seen <= 1'b0;
          end else if (lp_trig) begin
            state <= LP_REQ;
            cnt <= '0;
            lp_req <= 1'b1;
            wake <= lp_wakeup_in;
            ctrl_seen <= 1'b0;
            data_seen <= 1'b0;
          end
        end
        CTRLUPD: begin
          if (ctrlupd_ack) ack_seen <= 1'b1;
          if (c1 >= TCTRLUPD_MIN && !ctrlupd_ack && (ack_seen || c1 >= TCTRLUPD_MAX)) begin
            state <= IDLE;
            cnt <= '0;
            ctrlupd_req <= 1'b0;
          end
        end
        PHYUPD: begin
          phyupd_ack <= phyupd_req;
          if (!phyupd_req) begin
            state <= IDLE;
            cnt <= '0;
          end
        end
        PHYMSTR: begin
          phymstr_ack <= phymstr_req;
          if (!phymstr_req) begin
            state <= IDLE;
            cnt <= '0;
          end
        end
        LP_REQ: begin
          ctrl_seen <= ctrl_seen | lp_ctrl_ack;
          data_seen <= data_seen | lp_data_ack;
          if ((ctrl_seen || lp_ctrl_ack) && (data_seen || lp_data_ack)) begin
            state <= LP_ACT;
            cnt <= '0;
          end else if (c1 >= TLP_RESP) begin
            state <= LP_EXIT;
            cnt <= '0;
            lp_req <= 1'b0;
            lp_err <= 1'b1;
          end
        end
        LP_ACT: if (!lp_trig || phyupd_req || phymstr_req || ctrlupd_pend) begin
          state <= LP_EXIT;
          cnt <= '0;
          lp_req <= 1'b0;
        end
        LP_EXIT: if (!lp_ctrl_ack && !lp_data_ack) begin
          state <= IDLE;
          cnt <= '0;
          wake <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dfi_upd_lp_ctrl.sv
// tb_dfi_upd_lp_ctrl: randomized scoreboard bench for dfi_upd_lp_ctrl
module tb_dfi_upd_lp_ctrl;
  localparam int EV_CU = 0, EV_PU = 1, EV_PM = 2, EV_ACT = 3, EV_LP = 4, EV_ERR = 5;
  typedef struct {int kind; int a; int b;} ev_t;
  logic clock, reset, init_start, ctrlupd_trig, lp_trig, ctrlupd_ack, phyupd_req, phymstr_req;
  logic lp_ctrl_ack, lp_data_ack;
  logic [5:0] lp_wakeup_in, lp_ctrl_wakeup, lp_data_wakeup;
  logic [1:0] phyupd_type;
  logic ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, lp_data_req, busy, lp_active, lp_err;
  logic [19:0] all_out;
  ev_t exp_q[$];
  int compared = 0, mismatched = 0;
  string ev_nm[6] = '{"cu_width", "pu_latency", "pm_latency", "lp_active_len", "lp_req_width", "lp_err_len"};

  dfi_upd_lp_ctrl dut (
    .clock(clock), .reset(reset), .init_start(init_start), .ctrlupd_trig(ctrlupd_trig),
    .lp_trig(lp_trig), .lp_wakeup_in(lp_wakeup_in), .ctrlupd_req(ctrlupd_req),
    .ctrlupd_ack(ctrlupd_ack), .phyupd_req(phyupd_req), .phyupd_type(phyupd_type),
    .phyupd_ack(phyupd_ack), .phymstr_req(phymstr_req), .phymstr_ack(phymstr_ack),
    .lp_ctrl_req(lp_ctrl_req), .lp_ctrl_wakeup(lp_ctrl_wakeup), .lp_ctrl_ack(lp_ctrl_ack),
    .lp_data_req(lp_data_req), .lp_data_wakeup(lp_data_wakeup), .lp_data_ack(lp_data_ack),
    .busy(busy), .lp_active(lp_active), .lp_err(lp_err)
  );

  assign all_out = {ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, lp_data_req,
                    lp_ctrl_wakeup, lp_data_wakeup, busy, lp_active, lp_err};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic push(input int k, input int a, input int b);
    exp_q.push_back('{k, a, b});
  endtask

  task automatic check_ev(input int k, input int a, input int b);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: unexpected event a=%0d b=%0d, none required", ev_nm[k], a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        mismatched++;
        $display("FAIL %s: got a=%0d b=%0d, required %s a=%0d b=%0d", ev_nm[k], a, b, ev_nm[e.kind], e.a, e.b);
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", nm, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_out(input int sel, input logic v, input string nm);
    logic s;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      s = sel == 0 ? ctrlupd_req : sel == 1 ? lp_ctrl_req : sel == 2 ? phyupd_ack : sel == 3 ? phymstr_ack : busy;
      if (s == v) return;
    end
    compared++;
    mismatched++;
    $display("FAIL timeout_%s: stayed %b, required %b", nm, !v, v);
  endtask

  // Monitor: turns DUT output edges into events and checks cycle invariants.
  initial begin
    logic p_cu = 0, p_pu = 0, p_pm = 0, p_act = 0, p_lp = 0, p_err = 0, p_pur = 0, p_pmr = 0, hold = 0, ok;
    int cu_w = 0, act_w = 0, lp_w = 0, err_w = 0, pu_t = 0, pm_t = 0;
    logic [5:0] cap = 0;
    forever begin
      @(negedge clock);
      pu_t = (phyupd_req && !p_pur) ? 0 : pu_t + 1;
      pm_t = (phymstr_req && !p_pmr) ? 0 : pm_t + 1;
      if (ctrlupd_req) cu_w = p_cu ? cu_w + 1 : 1;
      if (lp_active) act_w = p_act ? act_w + 1 : 1;
      if (lp_ctrl_req) lp_w = p_lp ? lp_w + 1 : 1;
      if (lp_err) err_w = p_err ? err_w + 1 : 1;
      if (lp_ctrl_req && !p_lp) begin
        cap = lp_ctrl_wakeup;
        hold = 1;
      end
      if (!ctrlupd_req && p_cu) check_ev(EV_CU, cu_w, 0);
      if (phyupd_ack && !p_pu) check_ev(EV_PU, pu_t, 0);
      if (phymstr_ack && !p_pm) check_ev(EV_PM, pm_t, 0);
      if (!lp_active && p_act) check_ev(EV_ACT, act_w, 0);
      if (!lp_ctrl_req && p_lp) check_ev(EV_LP, lp_w, int'(cap));
      if (!lp_err && p_err) check_ev(EV_ERR, err_w, 0);
      ok = !(phyupd_ack && phymstr_ack) && !(ctrlupd_req && (phyupd_ack || phymstr_ack))
        && !(lp_ctrl_req && (phyupd_ack || phymstr_ack || ctrlupd_req))
        && !(init_start && (ctrlupd_req || phyupd_ack || phymstr_ack || lp_ctrl_req))
        && lp_data_req == lp_ctrl_req && lp_data_wakeup == lp_ctrl_wakeup
        && (!(ctrlupd_req || phyupd_ack || phymstr_ack || lp_ctrl_req || lp_active) || busy)
        && !(lp_active && !lp_ctrl_req) && !(hold && busy && lp_ctrl_wakeup != cap);
      if (ok !== 1'bx) begin
        compared++;
        if (!ok) begin
          mismatched++;
          $display("FAIL invariant: outputs=%b init_start=%b captured_wakeup=%0d", all_out, init_start, cap);
        end
      end
      if (!busy) hold = 0;
      {p_cu, p_pu, p_pm, p_act, p_lp, p_err, p_pur, p_pmr} =
        {ctrlupd_req, phyupd_ack, phymstr_ack, lp_active, lp_ctrl_req, lp_err, phyupd_req, phymstr_req};
    end
  end

  // a=0: no ack. Otherwise ack high in cycles a..a+l-1 after req rises; req then
  // stays high at least the minimum and until the first cycle the ack is low.
  task automatic cu_run(input int a, input int l);
    push(EV_CU, a == 0 ? 32 : (a + l + 1 > 4 ? a + l + 1 : 4), 0);
    ctrlupd_trig = 1;
    cyc(1);
    ctrlupd_trig = 0;
    wait_out(0, 1, "cu_rise");
    if (a > 0) begin
      cyc(a);
      ctrlupd_ack = 1;
      cyc(l);
      ctrlupd_ack = 0;
    end
    wait_out(4, 0, "cu_idle");
    cyc(1);
  endtask

  task automatic cu_with_phy(input int k);
    push(EV_CU, 32, 0);
    push(EV_PU, 34 - k, 0);
    ctrlupd_trig = 1;
    cyc(1);
    ctrlupd_trig = 0;
    wait_out(0, 1, "cu_rise");
    cyc(k);
    phyupd_req = 1;
    wait_out(2, 1, "pu_ack");
    cyc(1);
    phyupd_req = 0;
    wait_out(4, 0, "cu_phy_idle");
    cyc(1);
  endtask

  task automatic lp_norm(input logic [5:0] wake, input int d, input int e, input int h, input int h1, input logic via_phy);
    if (via_phy) push(EV_PU, 2, 0);
    push(EV_ACT, h, 0);
    push(EV_LP, d + e + h + 1, int'(wake));
    lp_wakeup_in = wake;
    lp_trig = 1;
    phyupd_req = via_phy;
    if (via_phy) begin
      wait_out(2, 1, "pu_ack");
      cyc(h1);
      phyupd_req = 0;
    end
    wait_out(1, 1, "lp_rise");
    lp_wakeup_in = ~wake;
    cyc(d);
    lp_ctrl_ack = 1;
    cyc(1);
    lp_ctrl_ack = 0;
    cyc(e - 1);
    lp_data_ack = 1;
    cyc(h);
    lp_trig = 0;
    wait_out(1, 0, "lp_fall");
    cyc(1);
    lp_data_ack = 0;
    wait_out(4, 0, "lp_idle");
    cyc(1);
  endtask

  task automatic lp_timeout(input logic [5:0] wake, input logic ctrl_only);
    push(EV_LP, 8, int'(wake));
    push(EV_ERR, 1, 0);
    lp_wakeup_in = wake;
    lp_trig = 1;
    wait_out(1, 1, "lpt_rise");
    lp_wakeup_in = 6'($urandom);
    cyc(2);
    if (ctrl_only) lp_ctrl_ack = 1;
    else lp_data_ack = 1;
    wait_out(1, 0, "lpt_fall");
    lp_trig = 0;
    cyc(2);
    lp_ctrl_ack = 0;
    lp_data_ack = 0;
    wait_out(4, 0, "lpt_idle");
    cyc(1);
  endtask

  task automatic lp_pm(input logic [5:0] wake, input int d, input int h, input int g, input int hm);
    push(EV_ACT, h, 0);
    push(EV_LP, d + h + 1, int'(wake));
    push(EV_PM, g + 4, 0);
    lp_wakeup_in = wake;
    lp_trig = 1;
    wait_out(1, 1, "lpm_rise");
    cyc(d);
    lp_ctrl_ack = 1;
    lp_data_ack = 1;
    cyc(h);
    phymstr_req = 1;
    wait_out(1, 0, "lpm_fall");
    cyc(g);
    lp_ctrl_ack = 0;
    lp_data_ack = 0;
    lp_trig = 0;
    wait_out(3, 1, "pm_ack");
    cyc(hm);
    phymstr_req = 0;
    wait_out(4, 0, "lpm_idle");
    cyc(1);
  endtask

  initial begin
    {init_start, ctrlupd_trig, lp_trig, ctrlupd_ack, phyupd_req, phymstr_req, lp_ctrl_ack, lp_data_ack} = '0;
    lp_wakeup_in = '0;
    phyupd_type = 2'b01;
    reset = 1;
    cyc(2);
    reset = 0;
    @(negedge clock);
    chk("reset_state", int'(all_out), 0);
    @(negedge clock);
    chk("post_reset", int'(all_out), 0);
    cyc(1);
    cu_run(0, 0);
    for (int i = 0; i < 6; i++) cu_run(int'($urandom_range(6, 1)), int'($urandom_range(5, 1)));
    cu_with_phy(int'($urandom_range(20, 1)));
    lp_norm(6'($urandom), 2, 1, 3, 1, 1'b1);
    for (int i = 0; i < 4; i++)
      lp_norm(6'($urandom), int'($urandom_range(4, 1)), int'($urandom_range(2, 1)),
              int'($urandom_range(6, 1)), int'($urandom_range(3, 0)), 1'($urandom));
    lp_timeout(6'd5, 1'b1);
    lp_timeout(6'($urandom), 1'b0);
    for (int i = 0; i < 2; i++)
      lp_pm(6'($urandom), int'($urandom_range(5, 1)), int'($urandom_range(4, 1)),
            int'($urandom_range(3, 1)), int'($urandom_range(3, 0)));
    push(EV_PU, 2, 0);
    push(EV_CU, 32, 0);
    phyupd_req = 1;
    wait_out(2, 1, "co_pu_ack");
    cyc(1);
    for (int i = 0; i < 2; i++) begin
      ctrlupd_trig = 1;
      cyc(1);
      ctrlupd_trig = 0;
      cyc(1);
    end
    phyupd_req = 0;
    wait_out(0, 1, "co_cu_rise");
    wait_out(4, 0, "co_idle");
    cyc(3);
    @(negedge clock);
    chk("coalesce_idle", int'(busy), 0);
    cyc(1);
    push(EV_CU, 4, 0);
    ctrlupd_trig = 1;
    cyc(1);
    ctrlupd_trig = 0;
    wait_out(0, 1, "rst_cu_rise");
    cyc(2);
    ctrlupd_ack = 1;
    cyc(1);
    reset = 1;
    cyc(1);
    reset = 0;
    ctrlupd_ack = 0;
    @(negedge clock);
    chk("reset_mid_handshake", int'(all_out), 0);
    @(negedge clock);
    chk("reset_mid_after", int'(all_out), 0);
    cyc(3);
    @(negedge clock);
    chk("reset_no_resume", int'(busy), 0);
    cyc(1);
    init_start = 1;
    cyc(1);
    ctrlupd_trig = 1;
    cyc(1);
    ctrlupd_trig = 0;
    cyc(int'($urandom_range(10, 3)));
    @(negedge clock);
    chk("init_blocks", int'(all_out), 0);
    push(EV_CU, 32, 0);
    cyc(1);
    init_start = 0;
    wait_out(0, 1, "init_cu_rise");
    wait_out(4, 0, "init_idle");
    cyc(5);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL %s: event never seen, required a=%0d b=%0d", ev_nm[e.kind], e.a, e.b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dfi_upd_lp_ctrl.md
DFI_UPD_LP_CTRL -- requirements
Module: dfi_upd_lp_ctrl

Interface
REQ-001 SHALL have parameter TLP_RESP, default 8: max cycles to wait for lp_ctrl_ack and lp_data_ack.
REQ-002 SHALL have parameter TCTRLUPD_MIN, default 4: min cycles ctrlupd_req is held.
REQ-003 SHALL have parameter TCTRLUPD_MAX, default 32: cycles after which ctrlupd_req is dropped if no ack was seen.
REQ-004 SHALL have port clock, in, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port reset, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have port init_start, in, 1: initialization in progress; blocks all grants.
REQ-007 SHALL have port ctrlupd_trig, in, 1: one-cycle MC request for a controller update.
REQ-008 SHALL have port lp_trig, in, 1: level request for low-power entry.
REQ-009 SHALL have port lp_wakeup_in, in, 6: wakeup code for the LP request.
REQ-010 SHALL have ports ctrlupd_req out 1, and ctrlupd_ack in 1: DFI controller-update handshake.
REQ-011 SHALL have ports phyupd_req in 1, phyupd_type in 2 (unused), and phyupd_ack out 1: DFI PHY-update handshake.
REQ-012 SHALL have ports phymstr_req in 1, and phymstr_ack out 1: DFI PHY-master handshake.
REQ-013 SHALL have ports lp_ctrl_req out 1, lp_ctrl_wakeup out 6, lp_ctrl_ack in 1, lp_data_req out 1, lp_data_wakeup out 6, and lp_data_ack in 1: DFI low-power handshakes.
REQ-014 SHALL have ports busy out 1 (FSM not IDLE), lp_active out 1 (state LP_ACT), and lp_err out 1 (one-cycle LP timeout pulse).

Function
REQ-015 SHALL implement an FSM with the states IDLE, CTRLUPD, PHYUPD, PHYMSTR, LP_REQ, LP_ACT and LP_EXIT.
REQ-016 SHALL set ctrlupd_pend on ctrlupd_trig and clear it on entry to CTRLUPD; multiple triggers while pending SHALL coalesce into one update.
REQ-017 SHALL remain in IDLE with all outputs 0 while init_start=1, so no req or ack ever overlaps init_start.
REQ-018 SHALL, in IDLE with init_start=0, select the next state by priority: phymstr_req > phyupd_req > ctrlupd_pend > lp_trig.
REQ-019 SHALL drive ctrlupd_req=1 throughout CTRLUPD, registered on entry.
REQ-020 SHALL leave CTRLUPD for IDLE when count>=TCTRLUPD_MIN and ctrlupd_ack=0, provided either ack was seen high during this state or count reaches TCTRLUPD_MAX.
REQ-021 SHALL never drop ctrlupd_req while ctrlupd_ack=1.
REQ-022 SHALL defer phyupd_req or phymstr_req arriving during CTRLUPD until CTRLUPD exits, so ctrlupd_req and phyupd_ack are never both high.
REQ-023 SHALL drive phyupd_ack=1 in PHYUPD, asserted the cycle after entry.
REQ-024 SHALL, in PHYUPD, when phyupd_req=0, drop phyupd_ack on the next edge and return to IDLE.
REQ-025 SHALL give a phyupd_req seen in IDLE phyupd_ack within 2 cycles.
REQ-026 SHALL apply the same handshake to PHYMSTR using phymstr_req/phymstr_ack.
REQ-027 SHALL never assert phyupd_ack and phymstr_ack together.
REQ-028 SHALL, in LP_REQ, drive lp_ctrl_req=lp_data_req=1 with both wakeup outputs = lp_wakeup_in, captured on entry and held stable through LP_EXIT.
REQ-029 SHALL record each LP ack separately and move to LP_ACT once both acks have been seen.
REQ-030 SHALL, if TLP_RESP cycles elapse in LP_REQ without both acks, drop both LP reqs next edge, pulse lp_err, and go to LP_EXIT.
REQ-031 SHALL hold both LP reqs in LP_ACT, going to LP_EXIT when lp_trig=0, phyupd_req=1, phymstr_req=1 or ctrlupd_pend=1.
REQ-032 SHALL drive both LP reqs 0 in LP_EXIT and return to IDLE when lp_ctrl_ack=0 and lp_data_ack=0.
REQ-033 SHALL use a single 6-bit state counter that clears on every state change and saturates at its maximum.

Reset
REQ-034 SHALL, on reset=1 at a posedge, put the FSM in IDLE and set ctrlupd_pend=0, counter=0 and every output 0, including mid-handshake.
REQ-035 SHALL hold all outputs 0 on the first cycle after reset deasserts.

Verification
REQ-036 SHALL verify: ctrlupd_trig pulse, PHY acks cycles 2-5 -> ctrlupd_req high >=4 cycles and held until ack low, then IDLE.
REQ-037 SHALL verify: ctrlupd_trig with no ack -> ctrlupd_req high exactly 32 cycles, then 0.
REQ-038 SHALL verify: phyupd_req and lp_trig rise together in IDLE -> phyupd_ack within 2 cycles, no LP req until phyupd completes.
REQ-039 SHALL verify: lp_trig=1, lp_wakeup_in=5, only lp_ctrl_ack returns -> reqs drop after 8 cycles, lp_err pulses once, wakeup outputs=5 throughout.
REQ-040 SHALL verify: in LP_ACT, phymstr_req=1 -> LP reqs drop, acks fall, then phymstr_ack=1; phyupd_ack stays 0.
REQ-041 SHALL verify: reset=1 during CTRLUPD with ctrlupd_ack=1 -> all outputs 0 next cycle; init_start=1 with ctrlupd_trig -> no req until init_start=0.
